// File: rtl/sbox.sv
// AES byte substitution shared by the key and cipher datapaths.
// s=0 selects the forward S-box, s=1 the inverse; both are built from GF(2^8) inversion.
module sbox (
   input  logic       s,
   input  logic [7:0] a,
   output logic [7:0] d
);

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] m;
      p = '0;
      m = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ m;
         m = xt(m);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         acc = gmul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x, input int unsigned n);
      return (x << n) | (x >> (8 - n));
   endfunction

   logic [7:0] w_inv;

   always_comb begin
      w_inv = '0;
      d     = '0;
      if (s) begin
         d = ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
      end else begin
         w_inv = ginv(a);
         d     = w_inv ^ rl(w_inv, 1) ^ rl(w_inv, 2) ^ rl(w_inv, 3) ^ rl(w_inv, 4) ^ 8'h63;
      end
   end

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption key scheduler: expands forward to round 10, then streams
// round keys 10..0 by inverting the expansion recurrence one step per accept.
module aes_dec_key_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         kld,
   input  logic [127:0] key,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx
);

   typedef enum logic [1:0] {StIdle, StExpand, StStream} state_t;

   state_t       r_state, w_state_nxt;
   logic [127:0] r_k, w_k_nxt;
   logic [3:0]   r_r, w_r_nxt;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_b3;
   logic [31:0]  w_sub_in, w_rot, w_sub, w_t;
   logic [31:0]  w_f0, w_f1, w_f2, w_f3;
   logic [7:0]   w_rcon;
   logic [127:0] w_fwd, w_bwd;

   assign {w_w0, w_w1, w_w2, w_w3} = r_k;
   assign w_b3 = w_w3 ^ w_w2;

   // One S-box bank serves both directions; the backward step needs the recovered w3
   assign w_sub_in = (r_state == StStream) ? w_b3 : w_w3;
   assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      sbox u_sbox (
         .s (1'b0),
         .a (w_rot[8*g +: 8]),
         .d (w_sub[8*g +: 8])
      );
   end

   always_comb begin
      w_rcon = 8'h00;
      case (r_r)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_t   = w_sub ^ {w_rcon, 24'h000000};
   assign w_f0  = w_w0 ^ w_t;
   assign w_f1  = w_w1 ^ w_f0;
   assign w_f2  = w_w2 ^ w_f1;
   assign w_f3  = w_w3 ^ w_f2;
   assign w_fwd = {w_f0, w_f1, w_f2, w_f3};
   assign w_bwd = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_b3};

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_r_nxt     = r_r;
      // A load restarts from any state and swallows a coincident accept
      if (kld) begin
         w_state_nxt = StExpand;
         w_k_nxt     = key;
         w_r_nxt     = 4'd1;
      end else begin
         case (r_state)
            StExpand: begin
               w_k_nxt = w_fwd;
               if (r_r == 4'd10) w_state_nxt = StStream;
               else              w_r_nxt     = r_r + 4'd1;
            end
            StStream: begin
               if (rk_ready) begin
                  if (r_r == 4'd0) begin
                     w_state_nxt = StIdle;
                  end else begin
                     w_k_nxt = w_bwd;
                     w_r_nxt = r_r - 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_k     <= '0;
         r_r     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_r     <= w_r_nxt;
      end
   end

   assign busy     = (r_state != StIdle);
   assign rk_valid = (r_state == StStream);
   assign rk_out   = r_k;
   assign rk_idx   = r_r;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched: stimulus queues expected round keys,
// a negedge monitor pops and compares on every handshake accept.
module tb_aes_dec_key_sched;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         kld = 1'b0;
   logic [127:0] key = '0;
   logic         busy, rk_valid;
   logic         rk_ready = 1'b1;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;

   aes_dec_key_sched dut (
      .clk      (clk),
      .rst      (rst),
      .kld      (kld),
      .key      (key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_idx   (rk_idx)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] Fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] Zero10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   int           n_checks = 0;
   int           n_fail = 0;
   int           n_acc = 0;
   logic [131:0] exp_q[$];
   logic [7:0]   tb_sb[256];
   logic [127:0] m_rk[11];
   logic [127:0] fips_rk[11];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] m;
      p = '0;
      m = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ m;
         m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Independent S-box: brute-force inverse search then per-bit affine map
   task automatic build_sbox();
      logic [7:0] inv, c, b, xb;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         xb  = 8'(x);
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(xb, 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         tb_sb[x] = b;
      end
   endtask

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w0, w1, w2, w3, t;
      logic [7:0]  rc;
      rc = 8'h01;
      m_rk[0] = k;
      for (int r = 1; r <= 10; r++) begin
         {w0, w1, w2, w3} = m_rk[r-1];
         t  = {tb_sb[w3[23:16]], tb_sb[w3[15:8]], tb_sb[w3[7:0]], tb_sb[w3[31:24]]};
         t  = t ^ {rc, 24'h0};
         w0 = w0 ^ t;
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         m_rk[r] = {w0, w1, w2, w3};
         rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
   endtask

   // Call at posedge+1; returns one cycle later with kld sampled
   task automatic start_key(input logic [127:0] k);
      kld = 1'b1;
      key = k;
      exp_q.delete();
      n_acc = 0;
      if (k == Fips) begin
         for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), fips_rk[r]});
      end else begin
         model_expand(k);
         for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), m_rk[r]});
      end
      @(posedge clk);
      #1;
      kld = 1'b0;
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic wait_first(input logic [127:0] exp10);
      int n;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rk_valid) begin
            n = i;
            break;
         end
      end
      check("first_latency", 128'(n), 128'd11);
      check("first_idx", 128'(rk_idx), 128'd10);
      check("first_key", rk_out, exp10);
   endtask

   task automatic wait_done(input logic [127:0] k0, input bit rnd);
      for (int i = 0; i < 600; i++) begin
         if (rnd) rk_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!busy) break;
         @(posedge clk);
         #1;
      end
      check("done_busy", 128'(busy), 128'd0);
      check("done_valid", 128'(rk_valid), 128'd0);
      check("done_idx_hold", 128'(rk_idx), 128'd0);
      check("done_key_hold", rk_out, k0);
      check("accept_count", 128'(n_acc), 128'd11);
      check("queue_drained", 128'(exp_q.size()), 128'd0);
      rk_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [131:0] e;
      if (rst && rk_valid && rk_ready && !kld) begin
         n_acc++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_key: got idx %0d key %h, expected none", rk_idx, rk_out);
         end else begin
            e = exp_q.pop_front();
            check("sb_idx", 128'(rk_idx), 128'(e[131:128]));
            check("sb_key", rk_out, e[127:0]);
         end
      end
   end

   initial begin
      fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      build_sbox();

      #3;
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_valid", 128'(rk_valid), 128'd0);
      check("rst_out", rk_out, 128'd0);
      check("rst_idx", 128'(rk_idx), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 key, consumer always ready
      start_key(Fips);
      check("busy_after_kld", 128'(busy), 128'd1);
      wait_first(fips_rk[10]);
      @(posedge clk);
      #1;
      check("second_idx", 128'(rk_idx), 128'd9);
      check("second_key", rk_out, fips_rk[9]);
      wait_done(Fips, 1'b0);

      // All-zero key
      start_key('0);
      wait_first(Zero10);
      @(posedge clk);
      #1;
      wait_done('0, 1'b0);

      // Backpressure at round 7
      rk_ready = 1'b0;
      start_key(Fips);
      wait_first(fips_rk[10]);
      @(posedge clk);
      #1;
      rk_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rk_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_idx", 128'(rk_idx), 128'd7);
         check("bp_key", rk_out, fips_rk[7]);
         check("bp_valid", 128'(rk_valid), 128'd1);
      end
      @(posedge clk);
      #1;
      rk_ready = 1'b1;
      wait_done(Fips, 1'b0);

      // Random keys with random backpressure
      for (int n = 0; n < 100; n++) begin
         logic [127:0] k;
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         start_key(k);
         wait_done(k, 1'b1);
      end

      // Reload mid-EXPAND, then again mid-STREAM at round 5
      start_key({$urandom(), $urandom(), $urandom(), $urandom()});
      repeat (3) @(posedge clk);
      #1;
      start_key('0);
      wait_first(Zero10);
      repeat (5) @(posedge clk);
      #1;
      check("abort_at_idx", 128'(rk_idx), 128'd5);
      start_key(Fips);
      wait_first(fips_rk[10]);
      @(posedge clk);
      #1;
      wait_done(Fips, 1'b0);

      // Asynchronous reset while streaming
      start_key(Fips);
      wait_first(fips_rk[10]);
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("arst_busy", 128'(busy), 128'd0);
      check("arst_valid", 128'(rk_valid), 128'd0);
      check("arst_out", rk_out, 128'd0);
      check("arst_idx", 128'(rk_idx), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (15) begin
         @(negedge clk);
         check("post_rst_quiet", {126'd0, busy, rk_valid}, 128'd0);
      end
      @(posedge clk);
      #1;
      start_key(Fips);
      wait_first(fips_rk[10]);
      @(posedge clk);
      #1;
      wait_done(Fips, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
